// File: rtl/flash_responder_if.sv
// Handshake side of the 8-bit flash bus between the manager (master) and the responder (slave).
// FL_DATA is bidirectional, so it is a plain inout port on the responder rather than part of this interface.
interface flash_responder_if;
  logic [7:0] FL_ADDR;
  logic       FL_TRG;
  logic       FL_FLOW;
  logic       FL_STATUS;

  modport master (
    output FL_ADDR,
    output FL_TRG,
    output FL_FLOW,
    input  FL_STATUS
  );

  modport slave (
    input  FL_ADDR,
    input  FL_TRG,
    input  FL_FLOW,
    output FL_STATUS
  );
endinterface

// File: rtl/flash_responder.sv
// Target end of the flash bus: 256x8 array with programmable busy time, one-cycle done pulse, tristate read-back.
// Optional FLASH_BITCLEAR_EN: NOR-style 1->0 programming plus a full-array erase triggered by writing 8'h00 to 8'hFF.
module flash_responder #(
  parameter int         WRITE_CYCLES = 16,
  parameter int         READ_CYCLES  = 2,
  parameter logic [7:0] INIT_VALUE   = 8'hFF
) (
  input  logic               CLK_50MHZ,
  input  logic               RST,
  inout  wire  [7:0]         FL_DATA,
  flash_responder_if.slave   bus
);

  localparam int MAX_CYCLES = (WRITE_CYCLES > READ_CYCLES) ? WRITE_CYCLES : READ_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_WR,
    BUSY_RD,
    DONE,
    HOLD
`ifdef FLASH_BITCLEAR_EN
    , ERASE
`endif
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_addr;
  logic [7:0]       r_data;
  logic [7:0]       r_readLatch;
  logic             r_isRead;
  logic             w_accept;
  logic             w_countZero;
  logic             w_drive;
  logic             w_memWe;
  logic [7:0]       w_memAddr;
  logic [7:0]       w_memWData;
`ifdef FLASH_BITCLEAR_EN
  logic [7:0]       r_eraseIdx;
`endif

  // Array contents survive RST; only configuration loads the erased value.
  logic [7:0] r_mem [256] = '{default: INIT_VALUE};

  assign w_countZero = (r_count == '0);
  assign w_accept    = ((r_state == IDLE) || (r_state == HOLD)) && bus.FL_TRG;

  // A trigger in HOLD hands the bus back to the initiator in the same cycle.
  assign w_drive = ((r_state == DONE) || ((r_state == HOLD) && !bus.FL_TRG)) && bus.FL_FLOW;
  assign FL_DATA = w_drive ? r_readLatch : 8'hzz;

  assign bus.FL_STATUS = (r_state == DONE);

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_memWe    = 1'b0;
    w_memAddr  = r_addr;
`ifdef FLASH_BITCLEAR_EN
    w_memWData = r_mem[r_addr] & r_data;
`else
    w_memWData = r_data;
`endif
    case (r_state)
      IDLE: begin
        if (bus.FL_TRG) begin
          w_next = bus.FL_FLOW ? BUSY_RD : BUSY_WR;
        end
      end
      BUSY_WR: begin
        if (w_countZero) begin
`ifdef FLASH_BITCLEAR_EN
          // 8'hFF is the erase command address, never a storage byte.
          if (r_addr == 8'hFF) begin
            w_next = (r_data == 8'h00) ? ERASE : DONE;
          end else begin
            w_memWe = 1'b1;
            w_next  = DONE;
          end
`else
          w_memWe = 1'b1;
          w_next  = DONE;
`endif
        end
      end
      BUSY_RD: begin
        if (w_countZero) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = r_isRead ? HOLD : IDLE;
      end
      HOLD: begin
        if (bus.FL_TRG) begin
          w_next = bus.FL_FLOW ? BUSY_RD : BUSY_WR;
        end else if (!bus.FL_FLOW) begin
          w_next = IDLE;
        end
      end
`ifdef FLASH_BITCLEAR_EN
      ERASE: begin
        w_memWe    = 1'b1;
        w_memAddr  = r_eraseIdx;
        w_memWData = INIT_VALUE;
        if (r_eraseIdx == 8'hFF) begin
          w_next = DONE;
        end
      end
`endif
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // A reset on the commit edge must leave the array untouched.
  always_ff @(posedge CLK_50MHZ) begin
    if (w_memWe && !RST) begin
      r_mem[w_memAddr] <= w_memWData;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_count     <= '0;
      r_addr      <= 8'h00;
      r_data      <= 8'h00;
      r_readLatch <= 8'h00;
      r_isRead    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr   <= bus.FL_ADDR;
        r_isRead <= bus.FL_FLOW;
        r_count  <= bus.FL_FLOW ? RD_LOAD : WR_LOAD;
        if (!bus.FL_FLOW) begin
          r_data <= FL_DATA;
        end
      end else if (((r_state == BUSY_WR) || (r_state == BUSY_RD)) && !w_countZero) begin
        r_count <= r_count - CNT_W'(1);
      end
      if ((r_state == BUSY_RD) && w_countZero) begin
        r_readLatch <= r_mem[r_addr];
      end
    end
  end

`ifdef FLASH_BITCLEAR_EN
  always_ff @(posedge CLK_50MHZ) begin
    if (RST || (r_state != ERASE)) begin
      r_eraseIdx <= 8'h00;
    end else begin
      r_eraseIdx <= r_eraseIdx + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_flash_responder.sv
// Directed plus randomized bench for flash_responder, checked against a plain-array model of the flash store.
module tb_flash_responder;
  localparam int WR_CYC = 16;
  localparam int RD_CYC = 2;

  logic       CLK_50MHZ = 1'b0;
  logic       RST;
  logic       tbOe;
  logic [7:0] tbData;
  wire  [7:0] flData;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] model [256];

  assign flData = tbOe ? tbData : 8'hzz;

  flash_responder_if busIf();

  flash_responder #(
    .WRITE_CYCLES(WR_CYC),
    .READ_CYCLES (RD_CYC),
    .INIT_VALUE  (8'hFF)
  ) dut (
    .CLK_50MHZ(CLK_50MHZ),
    .RST      (RST),
    .FL_DATA  (flData),
    .bus      (busIf.slave)
  );

  always #5 CLK_50MHZ = ~CLK_50MHZ;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK_50MHZ);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int writeLatency(input logic [7:0] a, input logic [7:0] d);
`ifdef FLASH_BITCLEAR_EN
    if (a == 8'hFF && d == 8'h00) return WR_CYC + 1 + 256;
`endif
    return WR_CYC + 1;
  endfunction

  task automatic modelWrite(input logic [7:0] a, input logic [7:0] d);
`ifdef FLASH_BITCLEAR_EN
    if (a == 8'hFF) begin
      if (d == 8'h00) for (int i = 0; i < 256; i++) model[i] = 8'hFF;
    end else begin
      model[a] = model[a] & d;
    end
`else
    model[a] = d;
`endif
  endtask

  task automatic waitStatus(input int start, input int bound, output int k);
    k = start;
    while (busIf.FL_STATUS !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
  endtask

  task automatic countPulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (busIf.FL_STATUS === 1'b1) pulses++;
      tick();
    end
  endtask

  task automatic applyStimulus(input logic flow, input logic [7:0] a, input logic [7:0] d);
    busIf.FL_ADDR = a;
    busIf.FL_FLOW = flow;
    busIf.FL_TRG  = 1'b1;
    tbOe          = !flow;
    tbData        = d;
    tick();
    busIf.FL_TRG  = 1'b0;
    tbOe          = 1'b0;
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [7:0] d, input string tag);
    int k;
    applyStimulus(1'b0, a, d);
    waitStatus(1, 400, k);
    checkOutput({tag, "_wlat"}, k, writeLatency(a, d));
    modelWrite(a, d);
    tick();
    checkOutput({tag, "_wpulse"}, {31'd0, busIf.FL_STATUS}, 32'd0);
  endtask

  task automatic doRead(input logic [7:0] a, input string tag);
    int k;
    applyStimulus(1'b1, a, 8'h00);
    waitStatus(1, 50, k);
    checkOutput({tag, "_rlat"}, k, RD_CYC + 1);
    checkOutput({tag, "_done"}, {24'd0, flData}, {24'd0, model[a]});
    tick();
    checkOutput({tag, "_hold"}, {24'd0, flData}, {24'd0, model[a]});
    checkOutput({tag, "_rpulse"}, {31'd0, busIf.FL_STATUS}, 32'd0);
    busIf.FL_FLOW = 1'b0;
    tbOe   = 1'b1;
    tbData = 8'h00;
    #1;
    checkOutput({tag, "_rel"}, {24'd0, flData}, 32'd0);
    tick();
    tbOe = 1'b0;
  endtask

  task automatic enterHold(input logic [7:0] a);
    int k;
    applyStimulus(1'b1, a, 8'h00);
    waitStatus(1, 50, k);
    tick();
  endtask

  initial begin
    int k;
    int pulses;
    for (int i = 0; i < 256; i++) model[i] = 8'hFF;
    RST = 1'b1;
    tbOe = 1'b0;
    tbData = 8'h00;
    busIf.FL_ADDR = 8'h00;
    busIf.FL_FLOW = 1'b0;
    busIf.FL_TRG  = 1'b0;
    repeat (3) tick();
    checkOutput("rst_status", {31'd0, busIf.FL_STATUS}, 32'd0);
    tbOe = 1'b1;
    #1;
    checkOutput("rst_bus", {24'd0, flData}, 32'd0);
    tbOe = 1'b0;
    RST = 1'b0;
    tick();

    $display("[TB] erased read, write/readback");
    doRead(8'h10, "erased");
    doWrite(8'h10, 8'h5A, "w5a");
    doRead(8'h10, "r5a");
    doWrite(8'h10, 8'hA5, "wa5");
    doRead(8'h10, "ra5");

`ifdef FLASH_BITCLEAR_EN
    $display("[TB] bit-clear and erase");
    doWrite(8'h20, 8'hF0, "bcf0");
    doWrite(8'h20, 8'h3C, "bc3c");
    doRead(8'h20, "bcrd");
    checkOutput("bc_and", {24'd0, model[8'h20]}, 32'h30);
    doWrite(8'hFF, 8'h00, "erase");
    doRead(8'h20, "erased20");
`endif

    $display("[TB] extra triggers while busy and in DONE");
    applyStimulus(1'b0, 8'h30, 8'h11);
    busIf.FL_ADDR = 8'h31;
    busIf.FL_TRG  = 1'b1;
    tbOe   = 1'b1;
    tbData = 8'h99;
    repeat (3) tick();
    busIf.FL_TRG = 1'b0;
    tbOe = 1'b0;
    waitStatus(4, 50, k);
    checkOutput("extra_lat", k, WR_CYC + 1);
    busIf.FL_TRG = 1'b1;
    tbOe = 1'b1;
    tick();
    busIf.FL_TRG = 1'b0;
    tbOe = 1'b0;
    countPulses(25, pulses);
    checkOutput("extra_pulses", pulses, 0);
    modelWrite(8'h30, 8'h11);
    doRead(8'h30, "extra30");
    doRead(8'h31, "extra31");

    $display("[TB] reset aborts a program");
    applyStimulus(1'b0, 8'h05, 8'h77);
    repeat (4) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    countPulses(25, pulses);
    checkOutput("abort_pulses", pulses, 0);
    doRead(8'h05, "abort05");

    $display("[TB] write trigger from HOLD");
    enterHold(8'h31);
    checkOutput("hold_drive", {24'd0, flData}, {24'd0, model[8'h31]});
    busIf.FL_ADDR = 8'h40;
    busIf.FL_FLOW = 1'b0;
    busIf.FL_TRG  = 1'b1;
    tbOe   = 1'b1;
    tbData = 8'h3C;
    #1;
    checkOutput("hold_wrel", {24'd0, flData}, 32'h3C);
    tick();
    busIf.FL_TRG = 1'b0;
    tbOe = 1'b0;
    waitStatus(1, 50, k);
    checkOutput("hold_wlat", k, WR_CYC + 1);
    modelWrite(8'h40, 8'h3C);
    tick();
    doRead(8'h40, "hold40");

    $display("[TB] read trigger from HOLD");
    enterHold(8'h31);
    busIf.FL_ADDR = 8'h30;
    busIf.FL_TRG  = 1'b1;
    tbOe   = 1'b1;
    tbData = 8'h00;
    #1;
    checkOutput("hold_rrel", {24'd0, flData}, 32'd0);
    tick();
    busIf.FL_TRG = 1'b0;
    tbOe = 1'b0;
    waitStatus(1, 50, k);
    checkOutput("hold_rlat", k, RD_CYC + 1);
    checkOutput("hold_rdata", {24'd0, flData}, {24'd0, model[8'h30]});
    busIf.FL_FLOW = 1'b0;
    tick();
    tick();

    $display("[TB] reset in HOLD");
    enterHold(8'h31);
    RST = 1'b1;
    #1;
    checkOutput("rsthold_pre", {24'd0, flData}, {24'd0, model[8'h31]});
    tick();
    tbOe   = 1'b1;
    tbData = 8'h00;
    #1;
    checkOutput("rsthold_rel", {24'd0, flData}, 32'd0);
    tbOe = 1'b0;
    RST = 1'b0;
    busIf.FL_FLOW = 1'b0;
    tick();

    $display("[TB] random traffic");
    for (int n = 0; n < 30; n++) begin
      logic [7:0] a;
      logic [7:0] d;
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) doWrite(a, d, "rndw");
      else doRead(a, "rndr");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
